// File: rtl/cpu_issue_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_issue_seq_pkg
// Shared definitions for the CPU instruction-issue sequencer: the sequencer
// state encoding, the instruction word width, and the default program-buffer
// depth and wait-timeout values used as parameter defaults by the top level.
// -----------------------------------------------------------------------------
package cpu_issue_seq_pkg;

  localparam int DEPTH_DEF   = 16;  // program-buffer entries (power of two)
  localparam int TIMEOUT_DEF = 64;  // max cycles waiting on cpu_w per instruction
  localparam int WORD_W      = 16;  // instruction word width

  typedef enum logic [2:0] {
    IDLE,     // accept program writes and start requests
    ARM,      // wait for the CPU to report idle before the first load
    LOAD,     // present buffer[pc] with the load strobe
    START,    // pulse the CPU start strobe, instruction word held
    WAIT_LO,  // wait for the CPU to leave its wait state
    WAIT_HI,  // wait for the CPU to return to its wait state
    DONE      // one-cycle completion pulse
  } state_e;

endpackage : cpu_issue_seq_pkg

// File: rtl/cpu_issue_seq_prog_buf.sv
// -----------------------------------------------------------------------------
// cpu_issue_seq_prog_buf
// Program buffer for the issue sequencer: DEPTH x WIDTH storage with one
// synchronous write port and one asynchronous (combinational) read port.
//
// Ports
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  buffer[raddr], combinational
// -----------------------------------------------------------------------------
module cpu_issue_seq_prog_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto plain RAM/regfile
  // cells; the program survives a sequencer reset by design.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : cpu_issue_seq_prog_buf

// File: rtl/cpu_issue_seq.sv
// -----------------------------------------------------------------------------
// cpu_issue_seq
// Feeds a small CPU one instruction at a time from a program buffer. Each
// instruction is loaded into the CPU instruction register (cpu_load), the CPU
// is started (cpu_s), and the sequencer then waits for the CPU to drop and
// re-raise its wait flag (cpu_w) before issuing the next one. A watchdog
// aborts the run with a sticky err flag if the CPU takes too long.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   prog_we    in   program-buffer write enable (honoured only when idle)
//   prog_addr  in   program-buffer write address
//   prog_data  in   instruction word to write
//   start      in   run `count` instructions from address 0 (honoured only when idle)
//   count      in   instruction count 0..DEPTH, sampled on accepted start
//   cpu_w      in   CPU wait flag, 1 = CPU idle
//   cpu_in     out  instruction word to the CPU, held between loads
//   cpu_load   out  instruction-register load strobe
//   cpu_s      out  CPU start strobe
//   busy       out  run in progress
//   done       out  one-cycle pulse on normal completion
//   err        out  sticky timeout flag, cleared by the next non-empty start
//   pc         out  index of the current instruction
// -----------------------------------------------------------------------------
module cpu_issue_seq
  import cpu_issue_seq_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [WORD_W-1:0]        prog_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic                     cpu_w,
  output logic [WORD_W-1:0]        cpu_in,
  output logic                     cpu_load,
  output logic                     cpu_s,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] cpu_in_q, cpu_in_d;

  logic              buf_we;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              last_instr;
  logic              wdog_expired;

  // Program writes are only accepted while idle so a running program cannot
  // be modified underneath the sequencer.
  assign buf_we = prog_we && (state_q == IDLE);

  // The buffer is read one step ahead: when leaving WAIT_HI for the next LOAD
  // the word at pc+1 is captured, otherwise the word at pc (pc=0 from ARM).
  // At the last instruction pc+1 may wrap, but no load follows in that case.
  assign rd_addr = (state_q == WAIT_HI) ? pc_q + AW'(1) : pc_q;

  cpu_issue_seq_prog_buf #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) prog_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // count is never 0 while busy, so count-1 cannot underflow here.
  assign last_instr   = ({1'b0, pc_q} == (cnt_q - CW'(1)));
  // The watchdog holds the number of wait cycles already completed; the
  // TIMEOUT-th wait cycle is the one that sees TIMEOUT-1.
  assign wdog_expired = (wdog_q == WW'(TIMEOUT - 1));

  // NOTE: every signal assigned below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    busy_d   = busy_q;
    err_d    = err_q;
    cpu_in_d = cpu_in_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = count;
            pc_d    = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ARM;
          end
        end
      end

      ARM: begin
        if (cpu_w) begin
          cpu_in_d = rd_data;
          state_d  = LOAD;
        end
      end

      LOAD: state_d = START;

      START: begin
        wdog_d  = '0;
        state_d = WAIT_LO;
      end

      WAIT_LO, WAIT_HI: begin
        if (wdog_expired) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          pc_d    = '0;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + WW'(1);
          if (state_q == WAIT_LO) begin
            if (!cpu_w) state_d = WAIT_HI;
          end else if (cpu_w) begin
            if (last_instr) begin
              state_d = DONE;
            end else begin
              pc_d     = pc_q + AW'(1);
              cpu_in_d = rd_data;
              state_d  = LOAD;
            end
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        pc_d    = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cpu_in_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cpu_in_q <= cpu_in_d;
    end
  end

  // Strobes are decoded from the state register, so the asynchronous reset
  // clears them at once along with everything else.
  assign cpu_load = (state_q == LOAD);
  assign cpu_s    = (state_q == START);
  assign done     = (state_q == DONE);
  assign cpu_in   = cpu_in_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign pc       = pc_q;

endmodule : cpu_issue_seq
